ball_collision_detect: RTL and testbench

//  Opposite end of the MoveBall control interface: watches ballXValue/ballYValue/direction, drives the

---
 rtl/ball_collision_detect.sv | 171 +++++++++++++++++
 tb/tb_ball_collision_detect.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ball_collision_detect.sv
// Bounce, score, serve and game-over control for the Pong ball.
// Optional PADDLE_ZONE_EN macro enables the registered paddle hit-zone output.
module ball_collision_detect #(
    parameter int unsigned LEFT_PADDLE_X       = 16,
    parameter int unsigned RIGHT_PADDLE_X      = 224,
    parameter int unsigned PADDLE_HEIGHT       = 32,
    parameter int unsigned BALL_SIZE           = 4,
    parameter int unsigned MAX_TOP_POSITION    = 5,
    parameter int unsigned MIN_BOTTOM_POSITION = 235,
    parameter int unsigned LEFT_GOAL_X         = 2,
    parameter int unsigned RIGHT_GOAL_X        = 250,
    parameter int unsigned WIN_SCORE           = 7,
    parameter int unsigned SERVE_DELAY         = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ballXValue,
    input  logic [8:0] ballYValue,
    input  logic       direction,
    input  logic [8:0] leftPaddleY,
    input  logic [8:0] rightPaddleY,
    input  logic       startGame,
    output logic       changeXDirection,
    output logic [1:0] changeYDirection,
    output logic       ballRecenter,
    output logic [3:0] scoreLeft,
    output logic [3:0] scoreRight,
    output logic       gameOver,
    output logic [1:0] hitZone
);
    localparam int unsigned CNT_W = $clog2(SERVE_DELAY) + 1;
    localparam logic [9:0] LPX  = 10'(LEFT_PADDLE_X);
    localparam logic [9:0] RPX  = 10'(RIGHT_PADDLE_X);
    localparam logic [9:0] PH   = 10'(PADDLE_HEIGHT);
    localparam logic [9:0] BS   = 10'(BALL_SIZE);
    localparam logic [9:0] TOP  = 10'(MAX_TOP_POSITION);
    localparam logic [9:0] BOT  = 10'(MIN_BOTTOM_POSITION);
    localparam logic [9:0] LGX  = 10'(LEFT_GOAL_X);
    localparam logic [9:0] RGX  = 10'(RIGHT_GOAL_X);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {PLAY, HIT_LOCK, SERVE, GAME_OVER} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ylock, ylock_n;
    logic             cx_n;
    logic [1:0]       cy_n;
    logic [3:0]       sl_n, sr_n;

    // 10-bit copies so edge sums never wrap
    logic [9:0] bx, by, lpy, rpy;
    assign bx  = {2'b00, ballXValue};
    assign by  = {1'b0, ballYValue};
    assign lpy = {1'b0, leftPaddleY};
    assign rpy = {1'b0, rightPaddleY};

    logic left_overlap, right_overlap, left_hit, right_hit;
    logic goal_left, goal_right, x_clear, y_clear;
    assign left_overlap  = (by + BS > lpy) && (by < lpy + PH);
    assign right_overlap = (by + BS > rpy) && (by < rpy + PH);
    assign right_hit     = direction && (bx + BS >= RPX) && right_overlap;
    assign left_hit      = !direction && (bx <= LPX) && left_overlap;
    assign goal_left     = direction && (bx >= RGX);
    assign goal_right    = !direction && (bx <= LGX);
    assign x_clear       = (bx > LPX) && (bx + BS < RPX);
    assign y_clear       = (by > TOP) && (by + BS < BOT);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ylock_n = ylock;
        cx_n    = 1'b0;
        cy_n    = 2'b00;
        sl_n    = scoreLeft;
        sr_n    = scoreRight;

        if (state == PLAY || state == HIT_LOCK) begin
            if (!ylock && by <= TOP) begin
                cy_n    = 2'b01;
                ylock_n = 1'b1;
            end else if (!ylock && by + BS >= BOT) begin
                cy_n    = 2'b10;
                ylock_n = 1'b1;
            end else if (ylock && y_clear) begin
                ylock_n = 1'b0;
            end
        end

        case (state)
            PLAY, HIT_LOCK: begin
                // A paddle hit in PLAY outranks a goal; in HIT_LOCK goals outrank the unlock
                if (state == PLAY && (right_hit || left_hit)) begin
                    cx_n    = 1'b1;
                    state_n = HIT_LOCK;
                end else if (goal_left || goal_right) begin
                    if (goal_left && scoreLeft < WIN)
                        sl_n = scoreLeft + 4'd1;
                    if (goal_right && scoreRight < WIN)
                        sr_n = scoreRight + 4'd1;
                    state_n = (sl_n == WIN || sr_n == WIN) ? GAME_OVER : SERVE;
                    cnt_n   = '0;
                end else if (state == HIT_LOCK && x_clear) begin
                    state_n = PLAY;
                end
            end
            SERVE: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = PLAY;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAME_OVER: begin
                if (startGame) begin
                    sl_n    = '0;
                    sr_n    = '0;
                    cnt_n   = '0;
                    state_n = SERVE;
                end
            end
            default: state_n = PLAY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= PLAY;
            cnt              <= '0;
            ylock            <= 1'b0;
            changeXDirection <= 1'b0;
            changeYDirection <= 2'b00;
            ballRecenter     <= 1'b0;
            gameOver         <= 1'b0;
            scoreLeft        <= '0;
            scoreRight       <= '0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            ylock            <= ylock_n;
            changeXDirection <= cx_n;
            changeYDirection <= cy_n;
            ballRecenter     <= (state_n == SERVE);
            gameOver         <= (state_n == GAME_OVER);
            scoreLeft        <= sl_n;
            scoreRight       <= sr_n;
        end
    end

`ifdef PADDLE_ZONE_EN
    localparam logic [9:0] ZONE1 = 10'(PADDLE_HEIGHT / 3);
    localparam logic [9:0] ZONE2 = 10'(2 * PADDLE_HEIGHT / 3);
    logic [9:0] centre, pad;
    assign centre = by + 10'(BALL_SIZE / 2);
    assign pad    = right_hit ? rpy : lpy;

    // Offset compared as centre vs pad+threshold to avoid a signed subtraction
    always_ff @(posedge clock) begin
        if (!reset)
            hitZone <= 2'b00;
        else if (state == PLAY && (right_hit || left_hit))
            hitZone <= (centre < pad + ZONE1)  ? 2'b01 :
                       (centre >= pad + ZONE2) ? 2'b11 : 2'b10;
    end
`else
    assign hitZone = 2'b00;
`endif

endmodule

// File: tb/tb_ball_collision_detect.sv
// Randomized and directed bench for ball_collision_detect against a behavioural game model.
module tb_ball_collision_detect;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] ballXValue;
    logic [8:0] ballYValue;
    logic       direction;
    logic [8:0] leftPaddleY;
    logic [8:0] rightPaddleY;
    logic       startGame;
    logic       changeXDirection;
    logic [1:0] changeYDirection;
    logic       ballRecenter;
    logic [3:0] scoreLeft;
    logic [3:0] scoreRight;
    logic       gameOver;
    logic [1:0] hitZone;

    int n_vec = 0;
    int n_err = 0;

    ball_collision_detect dut (
        .clock(clock), .reset(reset), .ballXValue(ballXValue), .ballYValue(ballYValue),
        .direction(direction), .leftPaddleY(leftPaddleY), .rightPaddleY(rightPaddleY),
        .startGame(startGame), .changeXDirection(changeXDirection),
        .changeYDirection(changeYDirection), .ballRecenter(ballRecenter),
        .scoreLeft(scoreLeft), .scoreRight(scoreRight), .gameOver(gameOver), .hitZone(hitZone)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: who may bounce, who scores, how long the serve lasts
    localparam int M_PLAY = 0, M_LOCK = 1, M_SERVE = 2, M_OVER = 3;
    int m_mode, m_wait, m_sl, m_sr;
    bit m_ylock, m_valid = 0;
    int e_cx, e_cy, e_rec, e_go, e_zone;
    int bx, by, lp, rp, off;
    bit rhit, lhit, lgoal, rgoal;

    always @(posedge clock) begin
        if (!reset) begin
            m_mode = M_PLAY; m_wait = 0; m_sl = 0; m_sr = 0; m_ylock = 0;
            e_cx = 0; e_cy = 0; e_rec = 0; e_go = 0; e_zone = 0;
            m_valid = 1;
        end else begin
            bx = ballXValue; by = ballYValue; lp = leftPaddleY; rp = rightPaddleY;
            rhit  = direction  && (bx + 4 >= 224) && (by + 4 > rp) && (by < rp + 32);
            lhit  = !direction && (bx <= 16)      && (by + 4 > lp) && (by < lp + 32);
            lgoal = direction  && (bx >= 250);
            rgoal = !direction && (bx <= 2);
            e_cx = 0; e_cy = 0;
            if (m_mode == M_PLAY || m_mode == M_LOCK) begin
                if (!m_ylock && by <= 5) begin e_cy = 1; m_ylock = 1; end
                else if (!m_ylock && by + 4 >= 235) begin e_cy = 2; m_ylock = 1; end
                else if (m_ylock && by > 5 && by + 4 < 235) m_ylock = 0;
            end
            if (m_mode == M_PLAY && (rhit || lhit)) begin
                e_cx = 1;
`ifdef PADDLE_ZONE_EN
                off = by + 2 - (rhit ? rp : lp);
                e_zone = (off < 32 / 3) ? 1 : (off >= 64 / 3) ? 3 : 2;
`endif
                m_mode = M_LOCK;
            end else if ((m_mode == M_PLAY || m_mode == M_LOCK) && (lgoal || rgoal)) begin
                if (lgoal) m_sl = (m_sl + 1 > 7) ? 7 : m_sl + 1;
                if (rgoal) m_sr = (m_sr + 1 > 7) ? 7 : m_sr + 1;
                m_mode = (m_sl == 7 || m_sr == 7) ? M_OVER : M_SERVE;
                m_wait = 0;
            end else if (m_mode == M_LOCK && bx > 16 && bx + 4 < 224) begin
                m_mode = M_PLAY;
            end else if (m_mode == M_SERVE) begin
                m_wait++;
                if (m_wait == 16) begin m_mode = M_PLAY; m_wait = 0; end
            end else if (m_mode == M_OVER && startGame) begin
                m_sl = 0; m_sr = 0; m_wait = 0; m_mode = M_SERVE;
            end
            e_rec = (m_mode == M_SERVE);
            e_go  = (m_mode == M_OVER);
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("changeX", int'(changeXDirection), e_cx);
            check("changeY", int'(changeYDirection), e_cy);
            check("recenter", int'(ballRecenter), e_rec);
            check("gameOver", int'(gameOver), e_go);
            check("scoreLeft", int'(scoreLeft), m_sl);
            check("scoreRight", int'(scoreRight), m_sr);
            check("hitZone", int'(hitZone), e_zone);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_serve_done(input string name);
        int guard = 0;
        while (ballRecenter && guard < 40) begin
            cyc();
            guard++;
        end
        check(name, int'(guard < 40), 1);
    endtask

    initial begin
        int rec_cycles;
        reset = 1'b0; ballXValue = 8'd120; ballYValue = 9'd100; direction = 1'b1;
        leftPaddleY = 9'd100; rightPaddleY = 9'd100; startGame = 1'b0;

        cyc(2);
        check("reset_outputs", int'({changeXDirection, changeYDirection, ballRecenter,
                                     scoreLeft, scoreRight, gameOver, hitZone}), 0);
        reset = 1'b1;
        cyc(2);

        // right paddle hit, lockout, re-arm
        ballXValue = 8'd221; rightPaddleY = 9'd90;
        cyc();
        check("hit1_pulse", int'(changeXDirection), 1);
        cyc();
        check("hit1_once", int'(changeXDirection), 0);
        cyc(4);
        ballXValue = 8'd200;
        cyc();
        ballXValue = 8'd221;
        cyc();
        check("hit2_pulse", int'(changeXDirection), 1);

        // top and bottom borders
        ballXValue = 8'd120; ballYValue = 9'd5;
        cyc();
        check("top_pulse", int'(changeYDirection), 1);
        cyc(9);
        ballYValue = 9'd100;
        cyc();
        ballYValue = 9'd233;
        cyc();
        check("bottom_pulse", int'(changeYDirection), 2);
        cyc(3);
        ballYValue = 9'd100;
        cyc();

        // right paddle miss: left player scores and a 16-cycle serve follows
        ballXValue = 8'd250; rightPaddleY = 9'd0;
        cyc();
        check("goal_score", int'(scoreLeft), 1);
        ballXValue = 8'd120;
        rec_cycles = 0;
        for (int i = 0; i < 40 && ballRecenter; i++) begin
            rec_cycles++;
            cyc();
        end
        check("serve_len", rec_cycles, 16);

        // six more goals end the game
        for (int g = 0; g < 6; g++) begin
            ballXValue = 8'd250;
            cyc();
            ballXValue = 8'd120;
            wait_serve_done("serve_timeout");
        end
        check("final_score", int'(scoreLeft), 7);
        check("game_over", int'(gameOver), 1);
        ballXValue = 8'd221; rightPaddleY = 9'd90; ballYValue = 9'd5;
        cyc();
        check("over_no_x", int'(changeXDirection), 0);
        check("over_no_y", int'(changeYDirection), 0);
        ballXValue = 8'd120; ballYValue = 9'd100; startGame = 1'b1;
        cyc();
        startGame = 1'b0;
        check("restart_scores", int'({scoreLeft, scoreRight}), 0);
        check("restart_serve", int'(ballRecenter), 1);
        wait_serve_done("restart_timeout");

        // paddle zones
        ballXValue = 8'd221; ballYValue = 9'd88;
        cyc();
        check("zone_hit_a", int'(changeXDirection), 1);
`ifdef PADDLE_ZONE_EN
        check("zone_top", int'(hitZone), 1);
`else
        check("zone_off_a", int'(hitZone), 0);
`endif
        ballXValue = 8'd200;
        cyc();
        ballXValue = 8'd221; ballYValue = 9'd112;
        cyc();
`ifdef PADDLE_ZONE_EN
        check("zone_bottom", int'(hitZone), 3);
`else
        check("zone_off_b", int'(hitZone), 0);
`endif
        ballXValue = 8'd120; ballYValue = 9'd100;
        cyc();

        // random play
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) != 0);
            startGame    = ($urandom_range(0, 29) == 0);
            direction    = 1'($urandom_range(0, 1));
            ballXValue   = 8'($urandom_range(0, 255));
            ballYValue   = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                                       : 9'($urandom_range(0, 240));
            leftPaddleY  = 9'($urandom_range(0, 240));
            rightPaddleY = 9'($urandom_range(0, 240));
            cyc();
        end
        reset = 1'b1; startGame = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
